// File: rtl/fib_fd_seq_pkg.sv
// Shared definitions for the fast-doubling Fibonacci engine: state encoding and iteration length.
package fib_fd_seq_pkg;

    localparam int unsigned FIB_ITER_CYCLES = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MUL_C  = 3'd1,
        ST_MUL_AA = 3'd2,
        ST_MUL_BB = 3'd3,
        ST_UPDATE = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/fib_fd_seq_mul.sv
// Combinational array multiplier: sums shifted partial products of x for each set bit of y.
module mul #(
    parameter int unsigned bw = 8
) (
    input  logic [bw-1:0]   x,
    input  logic [bw-1:0]   y,
    output logic [2*bw-1:0] p
);

    always_comb begin
        p = '0;
        for (int unsigned k = 0; k < bw; k++) begin
            if (y[k]) begin
                p = p + ({{bw{1'b0}}, x} << k);
            end
        end
    end

endmodule

// File: rtl/fib_fd_seq.sv
// Fast-doubling Fibonacci engine, F(n) mod 2^BW, one shared multiplier over NW iterations.
// Optional overflow flag enabled by defining FIB_OVF_DETECT_EN.
module fib_fd_seq
    import fib_fd_seq_pkg::*;
#(
    parameter int unsigned BW = 8,
    parameter int unsigned NW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [NW-1:0] n,
    output logic          idle,
    output logic          done,
    output logic [BW-1:0] fib
`ifdef FIB_OVF_DETECT_EN
    ,
    output logic          ovf
`endif
);

    localparam int unsigned IW = (NW > 1) ? $clog2(NW) : 1;

    state_t          state;
    logic [BW-1:0]   a, b, c, t;
    logic [NW-1:0]   nr;
    logic [IW-1:0]   i;

    logic [BW+1:0]   twob_a;
    logic [BW-1:0]   mul_x, mul_y;
    logic [2*BW-1:0] prod;
    logic [BW:0]     d_full, sum_full;
    logic [BW-1:0]   a_nxt, b_nxt;

    // 2b - a kept two bits wider so a wrap above or below the range is visible
    assign twob_a   = {1'b0, b, 1'b0} - {2'b00, a};
    assign d_full   = {1'b0, t} + {1'b0, prod[BW-1:0]};
    assign sum_full = {1'b0, c} + {1'b0, t};
    assign a_nxt    = nr[i] ? t : c;
    assign b_nxt    = nr[i] ? sum_full[BW-1:0] : t;

    // Operand mux: zero outside the multiply states
    always_comb begin
        mul_x = '0;
        mul_y = '0;
        case (state)
            ST_MUL_C: begin
                mul_x = a;
                mul_y = twob_a[BW-1:0];
            end
            ST_MUL_AA: begin
                mul_x = a;
                mul_y = a;
            end
            ST_MUL_BB: begin
                mul_x = b;
                mul_y = b;
            end
            default: ;
        endcase
    end

    mul #(.bw(BW)) u_mul (
        .x(mul_x),
        .y(mul_y),
        .p(prod)
    );

`ifndef FIB_OVF_DETECT_EN
    logic unused_hi;
    assign unused_hi = &{1'b0, prod[2*BW-1:BW], twob_a[BW+1:BW], d_full[BW], sum_full[BW]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            a     <= '0;
            b     <= '0;
            c     <= '0;
            t     <= '0;
            nr    <= '0;
            i     <= '0;
            idle  <= 1'b1;
            done  <= 1'b0;
            fib   <= '0;
`ifdef FIB_OVF_DETECT_EN
            ovf   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        nr    <= n;
                        a     <= '0;
                        b     <= BW'(1);
                        i     <= IW'(NW - 1);
                        idle  <= 1'b0;
                        state <= ST_MUL_C;
`ifdef FIB_OVF_DETECT_EN
                        ovf   <= 1'b0;
`endif
                    end else begin
                        idle  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                ST_MUL_C: begin
                    c     <= prod[BW-1:0];
                    state <= ST_MUL_AA;
`ifdef FIB_OVF_DETECT_EN
                    if ((|prod[2*BW-1:BW]) || (|twob_a[BW+1:BW])) ovf <= 1'b1;
`endif
                end
                ST_MUL_AA: begin
                    t     <= prod[BW-1:0];
                    state <= ST_MUL_BB;
`ifdef FIB_OVF_DETECT_EN
                    if (|prod[2*BW-1:BW]) ovf <= 1'b1;
`endif
                end
                ST_MUL_BB: begin
                    t     <= d_full[BW-1:0];
                    state <= ST_UPDATE;
`ifdef FIB_OVF_DETECT_EN
                    if ((|prod[2*BW-1:BW]) || d_full[BW]) ovf <= 1'b1;
`endif
                end
                ST_UPDATE: begin
                    a <= a_nxt;
                    b <= b_nxt;
`ifdef FIB_OVF_DETECT_EN
                    // c+d only matters when it becomes the new b
                    if (nr[i] && sum_full[BW]) ovf <= 1'b1;
`endif
                    if (i == '0) begin
                        fib   <= a_nxt;
                        done  <= 1'b1;
                        idle  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        i     <= i - IW'(1);
                        state <= ST_MUL_C;
                    end
                end
                default: begin
                    idle  <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fib_fd_seq.sv
// Directed self-checking bench for fib_fd_seq (BW=8, NW=4); ovf checks when FIB_OVF_DETECT_EN is defined.
module tb_fib_fd_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] n;
    logic       idle;
    logic       done;
    logic [7:0] fib;
`ifdef FIB_OVF_DETECT_EN
    logic       ovf;
`endif

    int passed = 0;
    int total  = 0;

    fib_fd_seq #(.BW(8), .NW(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .n    (n),
        .idle (idle),
        .done (done),
        .fib  (fib)
`ifdef FIB_OVF_DETECT_EN
        ,
        .ovf  (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] fib_ref(input int k);
        logic [7:0] x, y, s;
        x = 8'd0;
        y = 8'd1;
        for (int j = 0; j < k; j++) begin
            s = x + y;
            x = y;
            y = s;
        end
        return x;
    endfunction

    // Pulse start for one cycle; cyc counts edges with the accepting edge as 1
    task automatic run_n(input logic [3:0] nv, output int cyc, output logic seen);
        @(negedge clk);
        n     = nv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 1;
        seen  = 1'b0;
        while (!seen && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        n     = '0;
        #12;
        total++; if (idle !== 1'b1) $display("FAIL reset_idle got=%b exp=1", idle); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else passed++;
        total++; if (fib !== 8'd0) $display("FAIL reset_fib got=%0d exp=0", fib); else passed++;
`ifdef FIB_OVF_DETECT_EN
        total++; if (ovf !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", ovf); else passed++;
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int cyc;
        logic seen;
        run_n(4'd10, cyc, seen);
        total++; if (!seen || cyc != 17) $display("FAIL basic_latency got=%0d seen=%b exp=17", cyc, seen); else passed++;
        total++; if (fib !== 8'd55) $display("FAIL basic_fib got=%0d exp=55", fib); else passed++;
        total++; if (idle !== 1'b1) $display("FAIL basic_idle got=%b exp=1", idle); else passed++;
`ifdef FIB_OVF_DETECT_EN
        total++; if (ovf !== 1'b0) $display("FAIL basic_ovf got=%b exp=0", ovf); else passed++;
`endif
        @(posedge clk);
        #1;
        total++; if (done !== 1'b0) $display("FAIL basic_done_pulse got=%b exp=0", done); else passed++;
        total++; if (fib !== 8'd55) $display("FAIL basic_fib_hold got=%0d exp=55", fib); else passed++;
    endtask

    task automatic test_small_n();
        int cyc;
        logic seen;
        run_n(4'd0, cyc, seen);
        total++; if (!seen || cyc != 17) $display("FAIL n0_latency got=%0d exp=17", cyc); else passed++;
        total++; if (fib !== 8'd0) $display("FAIL n0_fib got=%0d exp=0", fib); else passed++;
        run_n(4'd1, cyc, seen);
        total++; if (!seen || cyc != 17) $display("FAIL n1_latency got=%0d exp=17", cyc); else passed++;
        total++; if (fib !== 8'd1) $display("FAIL n1_fib got=%0d exp=1", fib); else passed++;
    endtask

    task automatic test_wrap();
        int cyc;
        logic seen;
        logic [7:0] exp_f [3];
        exp_f[0] = 8'd144;
        exp_f[1] = 8'd233;
        exp_f[2] = 8'd121;
        for (int j = 0; j < 3; j++) begin
            run_n(4'(12 + j), cyc, seen);
            total++; if (!seen || fib !== exp_f[j]) $display("FAIL wrap_fib n=%0d got=%0d exp=%0d", 12 + j, fib, exp_f[j]); else passed++;
`ifdef FIB_OVF_DETECT_EN
            total++; if (ovf !== (j != 0)) $display("FAIL wrap_ovf n=%0d got=%b exp=%b", 12 + j, ovf, j != 0); else passed++;
`endif
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic seen;
        @(negedge clk);
        n     = 4'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc < 60) begin
            n = 4'(cyc);
            @(posedge clk);
            #1;
            cyc++;
            if (done) seen = 1'b1;
        end
        total++; if (!seen || cyc != 17) $display("FAIL held_latency got=%0d exp=17", cyc); else passed++;
        total++; if (fib !== 8'd13) $display("FAIL held_fib got=%0d exp=13", fib); else passed++;
        n = 4'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        total++; if (idle !== 1'b0) $display("FAIL b2b_no_idle got=%b exp=0", idle); else passed++;
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) seen = 1'b1;
        end
        total++; if (!seen || cyc != 17) $display("FAIL b2b_latency got=%0d exp=17", cyc); else passed++;
        total++; if (fib !== 8'd5) $display("FAIL b2b_fib got=%0d exp=5", fib); else passed++;
    endtask

    task automatic test_reset_abort();
        int cyc;
        logic seen;
        logic saw_done;
        @(negedge clk);
        n     = 4'd10;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (idle !== 1'b1) $display("FAIL abort_idle got=%b exp=1", idle); else passed++;
        total++; if (fib !== 8'd0) $display("FAIL abort_fib got=%0d exp=0", fib); else passed++;
        saw_done = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        total++; if (saw_done !== 1'b0) $display("FAIL abort_no_done got=%b exp=0", saw_done); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        run_n(4'd10, cyc, seen);
        total++; if (!seen || cyc != 17) $display("FAIL abort_rerun_latency got=%0d exp=17", cyc); else passed++;
        total++; if (fib !== 8'd55) $display("FAIL abort_rerun_fib got=%0d exp=55", fib); else passed++;
    endtask

    task automatic test_sweep();
        int cyc;
        logic seen;
        for (int k = 0; k < 16; k++) begin
            run_n(4'(k), cyc, seen);
            total++; if (!seen || cyc != 17 || fib !== fib_ref(k)) $display("FAIL sweep_fib n=%0d got=%0d cyc=%0d exp=%0d", k, fib, cyc, fib_ref(k)); else passed++;
`ifdef FIB_OVF_DETECT_EN
            total++; if (ovf !== (k >= 13)) $display("FAIL sweep_ovf n=%0d got=%b exp=%b", k, ovf, k >= 13); else passed++;
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_small_n();
        test_wrap();
        test_back_to_back();
        test_reset_abort();
        test_sweep();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
